// File: rtl/adc_frame_ctrl_if.sv
// Byte-level handshake between the ADC frame controller and the SPI master.
// The frame controller issues transmit requests and consumes received bytes;
// the SPI master answers with ready and receive-valid strobes.
interface adc_frame_ctrl_if;
    logic [7:0] spi_tx_byte;
    logic       spi_tx_dv;
    logic       spi_tx_ready;
    logic       spi_rx_dv;
    logic [7:0] spi_rx_byte;

    modport master (
        output spi_tx_byte,
        output spi_tx_dv,
        input  spi_tx_ready,
        input  spi_rx_dv,
        input  spi_rx_byte
    );

    modport slave (
        input  spi_tx_byte,
        input  spi_tx_dv,
        output spi_tx_ready,
        output spi_rx_dv,
        output spi_rx_byte
    );
endinterface

// File: rtl/adc_frame_ctrl.sv
// ADC frame controller: once per sample tick, runs one 16-bit conversion frame
// (two SPI bytes) against an ADC128S022-style converter, drives its chip
// select, and publishes the 12-bit result tagged with its channel.
// The converter returns the conversion addressed in the previous frame, so
// the result carries the channel sent one frame earlier and the first frame
// after reset only primes the pipeline.
module adc_frame_ctrl #(
    parameter int SAMPLE_DIV = 2500,
    parameter int CS_SETUP   = 4,
    parameter int CS_HOLD    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [2:0]          channel,
    adc_frame_ctrl_if.master    spi,
    output logic                adc_cs_n,
    output logic [11:0]         sample,
    output logic [2:0]          sample_ch,
    output logic                sample_valid,
    output logic                overrun
);

    localparam int TIMER_W = $clog2(SAMPLE_DIV);
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]   SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND_MSB,
        WAIT_MSB,
        SEND_LSB,
        WAIT_LSB,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [TIMER_W-1:0] timer;
    logic               tick;

    logic               launch;
    logic               send_msb;
    logic               send_lsb;
    logic               take_msb;
    logic               take_lsb;

    logic [2:0]         cur_ch;
    logic [2:0]         prev_ch;
    logic [3:0]         msb_nib;
    logic               primed;

    assign tick = (timer == TIMER_LAST);

    // Free-running sample timer; enable only gates launches, not the cadence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Frame state and the shared setup/hold cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Frame sequencing: next state plus the one-cycle action strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        launch     = 1'b0;
        send_msb   = 1'b0;
        send_lsb   = 1'b0;
        take_msb   = 1'b0;
        take_lsb   = 1'b0;
        case (state)
            IDLE: begin
                if (tick && enable) begin
                    launch     = 1'b1;
                    cnt_next   = '0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = SEND_MSB;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            SEND_MSB: begin
                if (spi.spi_tx_ready) begin
                    send_msb   = 1'b1;
                    state_next = WAIT_MSB;
                end
            end
            WAIT_MSB: begin
                if (spi.spi_rx_dv) begin
                    take_msb   = 1'b1;
                    state_next = SEND_LSB;
                end
            end
            SEND_LSB: begin
                if (spi.spi_tx_ready) begin
                    send_lsb   = 1'b1;
                    state_next = WAIT_LSB;
                end
            end
            WAIT_LSB: begin
                if (spi.spi_rx_dv) begin
                    take_lsb   = 1'b1;
                    cnt_next   = '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, channel pipeline and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs_n        <= 1'b1;
            spi.spi_tx_dv   <= 1'b0;
            spi.spi_tx_byte <= 8'h00;
            cur_ch          <= 3'd0;
            prev_ch         <= 3'd0;
            msb_nib         <= 4'd0;
            primed          <= 1'b0;
            sample          <= 12'd0;
            sample_ch       <= 3'd0;
            sample_valid    <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            adc_cs_n      <= (state_next == IDLE);
            spi.spi_tx_dv <= send_msb | send_lsb;
            sample_valid  <= 1'b0;
            overrun       <= tick && enable && (state != IDLE);
            if (send_msb) begin
                spi.spi_tx_byte <= {2'b00, cur_ch, 3'b000};
            end else if (send_lsb) begin
                spi.spi_tx_byte <= 8'h00;
            end
            if (launch) begin
                cur_ch <= channel;
            end
            if (take_msb) begin
                msb_nib <= spi.spi_rx_byte[3:0];
            end
            if (take_lsb) begin
                sample       <= {msb_nib, spi.spi_rx_byte};
                sample_ch    <= prev_ch;
                sample_valid <= primed;
                prev_ch      <= cur_ch;
                primed       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Self-checking bench for adc_frame_ctrl: a behavioural SPI master/ADC model
// answers each frame with a programmable 16-bit word, a monitor logs the
// frame activity, and per-frame expectations come from a hand-filled table
// plus hand-written sequences for backpressure, overrun, reset and enable.
module tb_adc_frame_ctrl;

    localparam int SAMPLE_DIV = 200;
    localparam int CS_SETUP   = 4;
    localparam int CS_HOLD    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  channel = 3'd0;
    logic        adc_cs_n;
    logic [11:0] sample;
    logic [2:0]  sample_ch;
    logic        sample_valid;
    logic        overrun;

    adc_frame_ctrl_if spi_bus();

    adc_frame_ctrl #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .CS_SETUP   (CS_SETUP),
        .CS_HOLD    (CS_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .channel      (channel),
        .spi          (spi_bus),
        .adc_cs_n     (adc_cs_n),
        .sample       (sample),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    always #10 clk = ~clk;

    // Model knobs, written only by the stimulus process.
    int          lat = 3;
    logic        hold_off = 1'b0;
    logic [15:0] resp_word = 16'h0000;

    int          busy;
    logic        byte_idx;

    // SPI master + ADC model: each requested byte answers after lat cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_bus.spi_tx_ready <= 1'b1;
            spi_bus.spi_rx_dv    <= 1'b0;
            spi_bus.spi_rx_byte  <= 8'h00;
            busy                 <= 0;
            byte_idx             <= 1'b0;
        end else begin
            spi_bus.spi_rx_dv <= 1'b0;
            if (adc_cs_n) byte_idx <= 1'b0;
            if (spi_bus.spi_tx_dv) begin
                busy                 <= lat;
                spi_bus.spi_tx_ready <= 1'b0;
            end else if (busy > 1) begin
                busy                 <= busy - 1;
                spi_bus.spi_tx_ready <= 1'b0;
            end else if (busy == 1) begin
                busy                 <= 0;
                spi_bus.spi_rx_dv    <= 1'b1;
                spi_bus.spi_rx_byte  <= byte_idx ? resp_word[7:0] : resp_word[15:8];
                byte_idx             <= ~byte_idx;
                spi_bus.spi_tx_ready <= !hold_off;
            end else begin
                spi_bus.spi_tx_ready <= !hold_off;
            end
        end
    end

    int          cyc = 0;
    int          valid_count = 0;
    int          tx_count = 0;
    logic [7:0]  tx_idx = 8'd0;
    int          overrun_count = 0;
    int          cs_fall_count = 0;
    int          bad_dv_count = 0;
    int          long_dv_count = 0;
    int          valid_cyc = 0;
    int          rx_cyc = 0;
    int          fall_cyc = 0;
    int          rise_cyc = 0;
    logic [11:0] last_sample = 12'd0;
    logic [2:0]  last_ch = 3'd0;
    logic [7:0]  tx_log [0:255];
    logic        prev_cs = 1'b1;
    logic        prev_dv = 1'b0;

    // Monitor: logs strobes, transmitted bytes and chip-select edges.
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_cs <= adc_cs_n;
        prev_dv <= spi_bus.spi_tx_dv;
        if (sample_valid) begin
            valid_count <= valid_count + 1;
            last_sample <= sample;
            last_ch     <= sample_ch;
            valid_cyc   <= cyc;
        end
        if (spi_bus.spi_rx_dv) rx_cyc <= cyc;
        if (spi_bus.spi_tx_dv) begin
            tx_log[tx_idx] <= spi_bus.spi_tx_byte;
            tx_idx         <= tx_idx + 8'd1;
            tx_count       <= tx_count + 1;
            if (!spi_bus.spi_tx_ready) bad_dv_count <= bad_dv_count + 1;
            if (prev_dv) long_dv_count <= long_dv_count + 1;
        end
        if (overrun) overrun_count <= overrun_count + 1;
        if (prev_cs && !adc_cs_n) begin
            cs_fall_count <= cs_fall_count + 1;
            fall_cyc      <= cyc;
        end
        if (!prev_cs && adc_cs_n) rise_cyc <= cyc;
    end

    typedef struct {
        logic        en;
        logic [2:0]  ch;
        logic [15:0] resp;
        logic        exp_valid;
        logic [11:0] exp_sample;
        logic [2:0]  exp_ch;
        logic [7:0]  exp_msb_byte;
    } frame_vec_t;

    frame_vec_t vecs [6];

    int         compared = 0;
    int         mismatched = 0;
    int         v_before = 0;
    int         t_before = 0;
    logic [7:0] t_idx_before = 8'd0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    task automatic wait_cs_fall(input int budget, input string name);
        int start;
        int n;
        start = cs_fall_count;
        n = 0;
        while (cs_fall_count == start && n < budget) begin
            step();
            n++;
        end
        if (cs_fall_count == start) timeout_fail(name);
    endtask

    task automatic wait_cs_rise(input int budget, input string name);
        int n;
        n = 0;
        while (adc_cs_n !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (adc_cs_n !== 1'b1) timeout_fail(name);
    endtask

    task automatic snapshot();
        v_before     = valid_count;
        t_before     = tx_count;
        t_idx_before = tx_idx;
    endtask

    task automatic apply_stimulus(input frame_vec_t v);
        channel   = v.ch;
        enable    = v.en;
        resp_word = v.resp;
        snapshot();
        wait_cs_fall(2 * SAMPLE_DIV + 50, "frame launch");
        wait_cs_rise(1000, "frame end");
        step();
        step();
    endtask

    task automatic check_output(input frame_vec_t v, input int exp_len);
        check("valid pulses", valid_count - v_before, {31'd0, v.exp_valid});
        if (v.exp_valid) begin
            check("sample", {20'd0, last_sample}, {20'd0, v.exp_sample});
            check("sample_ch", {29'd0, last_ch}, {29'd0, v.exp_ch});
            check("rx-to-valid latency", valid_cyc - rx_cyc, 1);
        end
        check("tx byte count", tx_count - t_before, 2);
        check("tx msb byte", {24'd0, tx_log[t_idx_before]}, {24'd0, v.exp_msb_byte});
        check("tx lsb byte", {24'd0, tx_log[t_idx_before + 8'd1]}, 0);
        if (exp_len > 0) check("cs low cycles", rise_cyc - fall_cyc, exp_len);
    endtask

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int fa, fb, fc, oa, ob, oc, falls, viol;
        frame_vec_t v;

        vecs[0] = '{1'b1, 3'd0, 16'h0ABC, 1'b0, 12'h000, 3'd0, 8'h00};
        vecs[1] = '{1'b1, 3'd0, 16'h0ABC, 1'b1, 12'hABC, 3'd0, 8'h00};
        vecs[2] = '{1'b1, 3'd5, 16'hF5A5, 1'b1, 12'h5A5, 3'd0, 8'h28};
        vecs[3] = '{1'b1, 3'd2, 16'h0123, 1'b1, 12'h123, 3'd5, 8'h10};
        vecs[4] = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 12'hFFF, 3'd2, 8'h38};
        vecs[5] = '{1'b1, 3'd7, 16'h0000, 1'b1, 12'h000, 3'd7, 8'h38};

        #3 rst_n = 1'b0;
        repeat (3) step();
        check("reset adc_cs_n", {31'd0, adc_cs_n}, 1);
        check("reset spi_tx_dv", {31'd0, spi_bus.spi_tx_dv}, 0);
        check("reset spi_tx_byte", {24'd0, spi_bus.spi_tx_byte}, 0);
        check("reset sample", {20'd0, sample}, 0);
        check("reset sample_ch", {29'd0, sample_ch}, 0);
        check("reset sample_valid", {31'd0, sample_valid}, 0);
        check("reset overrun", {31'd0, overrun}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], CS_SETUP + CS_HOLD + 6 + 2 * lat);
        end

        // Backpressure: ready held low while the controller sits in SEND_MSB.
        v = '{1'b1, 3'd1, 16'h0456, 1'b1, 12'h456, 3'd7, 8'h08};
        channel   = v.ch;
        resp_word = v.resp;
        hold_off  = 1'b1;
        snapshot();
        wait_cs_fall(2 * SAMPLE_DIV + 50, "backpressure launch");
        viol = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (spi_bus.spi_tx_dv !== 1'b0 || adc_cs_n !== 1'b0) viol++;
        end
        check("backpressure holds dv low, cs low", viol, 0);
        hold_off = 1'b0;
        wait_cs_rise(1000, "backpressure frame end");
        step();
        step();
        check_output(v, -1);

        // Overrun: a slow SPI stretches each frame past one tick period.
        channel   = 3'd4;
        resp_word = 16'h0789;
        lat       = 100;
        wait_cs_fall(2 * SAMPLE_DIV + 50, "overrun frame A");
        fa = fall_cyc;
        oa = overrun_count;
        wait_cs_fall(3 * SAMPLE_DIV, "overrun frame B");
        fb = fall_cyc;
        ob = overrun_count;
        wait_cs_fall(3 * SAMPLE_DIV, "overrun frame C");
        fc = fall_cyc;
        oc = overrun_count;
        check("overrun launch gap A-B", fb - fa, 2 * SAMPLE_DIV);
        check("overrun pulses A-B", ob - oa, 1);
        check("overrun launch gap B-C", fc - fb, 2 * SAMPLE_DIV);
        check("overrun pulses B-C", oc - ob, 1);
        wait_cs_rise(1000, "overrun frame C end");
        check("slow frame cs low cycles", rise_cyc - fall_cyc, CS_SETUP + CS_HOLD + 6 + 200);
        lat = 3;
        step();

        // Reset in WAIT_LSB: cs_n and tx_dv must drop without a clock edge.
        channel   = 3'd6;
        resp_word = 16'h0321;
        snapshot();
        wait_cs_fall(2 * SAMPLE_DIV + 50, "reset frame launch");
        begin
            int n;
            n = 0;
            while (tx_count - t_before < 2 && n < 100) begin
                step();
                n++;
            end
            if (tx_count - t_before < 2) timeout_fail("reset frame second byte");
        end
        rst_n = 1'b0;
        #1;
        check("async reset adc_cs_n", {31'd0, adc_cs_n}, 1);
        check("async reset spi_tx_dv", {31'd0, spi_bus.spi_tx_dv}, 0);
        repeat (3) step();
        rst_n = 1'b1;
        v = '{1'b1, 3'd6, 16'h0321, 1'b0, 12'h000, 3'd0, 8'h30};
        apply_stimulus(v);
        check_output(v, CS_SETUP + CS_HOLD + 6 + 2 * lat);
        v = '{1'b1, 3'd6, 16'h0654, 1'b1, 12'h654, 3'd6, 8'h30};
        apply_stimulus(v);
        check_output(v, CS_SETUP + CS_HOLD + 6 + 2 * lat);

        // Enable dropped during SETUP: frame finishes, then silence.
        v = '{1'b1, 3'd3, 16'h0BEE, 1'b1, 12'hBEE, 3'd6, 8'h18};
        channel   = v.ch;
        resp_word = v.resp;
        snapshot();
        wait_cs_fall(2 * SAMPLE_DIV + 50, "enable-drop launch");
        step();
        step();
        enable = 1'b0;
        wait_cs_rise(1000, "enable-drop frame end");
        step();
        step();
        check_output(v, CS_SETUP + CS_HOLD + 6 + 2 * lat);
        falls = cs_fall_count;
        repeat (5 * SAMPLE_DIV) step();
        check("no frames while disabled", cs_fall_count - falls, 0);
        v = '{1'b1, 3'd3, 16'h0CAF, 1'b1, 12'hCAF, 3'd3, 8'h18};
        apply_stimulus(v);
        check_output(v, CS_SETUP + CS_HOLD + 6 + 2 * lat);

        check("tx_dv while not ready", bad_dv_count, 0);
        check("tx_dv longer than one cycle", long_dv_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adc_frame_ctrl.md
Name: adc_frame_ctrl

Overview:
- Upstream stage of the PID loop. Sequences the byte-wide SPI master through one 16-bit ADC128S022-style conversion frame per sample tick, and drives the ADC chip select.
- Assembles the two received bytes into a 12-bit sample and tags it with its channel. Presents it with a one-cycle valid pulse, replacing free-running byte counting on the receive-valid strobe.

Parameters:
- SAMPLE_DIV, 2500, clk cycles between frame launches (20 kHz at 50 MHz); must be >= 2.
- CS_SETUP, 4, clk cycles from chip-select low to first byte request.
- CS_HOLD, 4, clk cycles from last byte received to chip-select high.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = launch frames on sample ticks.
- channel  in  3  ADC input to address.
- spi_tx_byte  out  8  byte to SPI master.
- spi_tx_dv  out  1  one-cycle transmit request to SPI master.
- spi_tx_ready  in  1  SPI master ready for next byte.
- spi_rx_dv  in  1  one-cycle receive-valid from SPI master.
- spi_rx_byte  in  8  byte received on MISO.
- adc_cs_n  out  1  ADC chip select, active low.
- sample  out  12  latest conversion result.
- sample_ch  out  3  channel the sample belongs to.
- sample_valid  out  1  one-cycle strobe, sample/sample_ch updated.
- overrun  out  1  one-cycle pulse: tick arrived while frame busy.

Behaviour:
- Reset values (asserted asynchronously, released synchronously): adc_cs_n=1, spi_tx_dv=0, spi_tx_byte=0, sample=0, sample_ch=0, sample_valid=0, overrun=0, state IDLE, timer=0, primed=0, prev_ch=0.
- Sample timer: runs whenever rst_n=1, independent of enable.
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted for the one cycle in which timer = SAMPLE_DIV-1.
- FSM states: IDLE, SETUP, SEND_MSB, WAIT_MSB, SEND_LSB, WAIT_LSB, HOLD.
  - IDLE: adc_cs_n=1. On tick with enable=1: latch channel into cur_ch, go to SETUP, drive adc_cs_n=0 from the next cycle.
  - SETUP: adc_cs_n=0. After CS_SETUP cycles, go to SEND_MSB.
  - SEND_MSB: wait for spi_tx_ready=1. In that cycle, register spi_tx_byte={2'b00,cur_ch,3'b000} and spi_tx_dv=1 (exactly one cycle), then go to WAIT_MSB.
  - WAIT_MSB: on spi_rx_dv, latch msb<=spi_rx_byte and go to SEND_LSB.
  - SEND_LSB: as SEND_MSB but with spi_tx_byte=8'h00, then go to WAIT_LSB.
  - WAIT_LSB: on spi_rx_dv, go to HOLD.
  - HOLD: adc_cs_n stays 0 for CS_HOLD cycles, then goes to 1 and the FSM returns to IDLE.
- Result publication: on the spi_rx_dv accepted in WAIT_LSB, the next cycle gives:
  - sample={msb[3:0],spi_rx_byte[7:0]}, with msb[7:4] discarded.
  - sample_ch=prev_ch.
  - sample_valid=1 only if primed=1.
  - Same edge: prev_ch<=cur_ch and primed<=1.
- Channel pipelining: the address sent in frame N selects the conversion returned in frame N+1.
  - The first frame after reset produces no sample_valid.
  - A channel change takes effect in the sample of the frame after the change frame.
- spi_rx_dv outside WAIT_MSB/WAIT_LSB is ignored. spi_tx_dv is never asserted while spi_tx_ready=0.
- overrun: pulses one cycle when tick occurs, enable=1 and state != IDLE. That tick is dropped; it is not queued.
- enable deasserted mid-frame: the frame completes and its result is published; no new frame launches. primed is retained.
- Reset mid-frame: adc_cs_n returns to 1 immediately (asynchronously), all state clears, and primed=0, so the next frame is a priming frame.
- Latency: launch tick to adc_cs_n low = 1 cycle. LSB spi_rx_dv to sample_valid = 1 cycle.
- Throughput: frame length = CS_SETUP + 2 SPI bytes + CS_HOLD + ~4 cycles. This must be < SAMPLE_DIV, otherwise every other tick overruns.

Test Plan:
- Basic frame: SAMPLE_DIV=200, channel=0, ADC model returns 0x0ABC on every frame. Response: first frame has no valid; second frame gives sample=0xABC, sample_ch=0, one valid pulse; tx bytes 0x00,0x00.
- Channel pipelining: channel=0 for frames 1-2, then 5 from frame 3. Response: frame 3 tx MSB byte=0x28, sample_ch=0; frame 4 sample_ch=5.
- Handshake backpressure: hold spi_tx_ready=0 for 20 cycles in SEND_MSB. Response: spi_tx_dv stays 0, then a single one-cycle pulse when ready rises; cs_n stays low throughout.
- Overrun: SAMPLE_DIV=10 with a slow SPI model (>10 cycles per frame). Response: overrun pulses once per dropped tick; frames never overlap; cs_n returns high between frames.
- Reset mid-frame: assert rst_n=0 in WAIT_LSB. Response: cs_n=1 and tx_dv=0 within the same cycle; after release, the first frame yields no valid and the second yields a valid.
- Enable drop: deassert enable in SETUP. Response: frame finishes and publishes its sample; no further cs_n activity over 5 tick periods; re-enable resumes with valid on the first frame.
